tick_delay_timer: RTL

//  Consumes the max_tick strobe produced by mod_m_counter and measures a programmable

---
 rtl/tick_delay_timer.sv | 106 ++++++++++
 1 files changed

// File: rtl/tick_delay_timer.sv
// Tick-counting delay timer: after start, counts delayPeriod tick strobes, then pulses done.
// Optional periodic mode: define TICK_DELAY_AUTORELOAD_EN to reload from delayPeriod on every done.
module tick_delay_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] delayPeriod,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] remaining
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   remaining_r;
    logic [W-1:0]   remaining_nxt_s;
    logic           busy_r;
    logic           done_r;

    // Next-state and next-count decode
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    remaining_nxt_s = delayPeriod;
                    if (delayPeriod != {W{1'b0}}) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // abort has priority over a coincident tick
                if (abort) begin
                    state_nxt_s     = ST_IDLE;
                    remaining_nxt_s = {W{1'b0}};
                end else if (tick) begin
                    if (remaining_r <= {{(W-1){1'b0}}, 1'b1}) begin
                        state_nxt_s     = ST_DONE;
                        remaining_nxt_s = {W{1'b0}};
                    end else begin
                        remaining_nxt_s = remaining_r - {{(W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_nxt_s     = ST_IDLE;
                    remaining_nxt_s = {W{1'b0}};
                end else begin
`ifdef TICK_DELAY_AUTORELOAD_EN
                    remaining_nxt_s = delayPeriod;
                    if (delayPeriod != {W{1'b0}}) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
`else
                    state_nxt_s = ST_IDLE;
`endif
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                remaining_nxt_s = {W{1'b0}};
            end
        endcase
    end

    // State, count and output registers; status flags are registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= {W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign remaining = remaining_r;

endmodule
